// File: rtl/mux_2_pkg.sv
// mux_2_pkg: shared types and defaults for the two-source round-robin mux stage
package mux_2_pkg;
  localparam int WORD_SIZE_DEFAULT = 32;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  typedef logic src_t;
endpackage

// File: rtl/mux_2_rr_stage_if.sv
// mux_2_rr_stage_if: one valid/ready word channel
interface mux_2_rr_stage_if #(parameter int W = mux_2_pkg::WORD_SIZE_DEFAULT);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/mux_2_rr_stage_arb_rr2.sv
// arb_rr2: combinational two-way round-robin grant favouring the source not served last
module arb_rr2
  import mux_2_pkg::*;
(
  input  logic valid_0_i,
  input  logic valid_1_i,
  input  src_t last_src_i,
  output src_t grant_o,
  output logic any_grant_o
);
  always_comb begin
    any_grant_o = valid_0_i | valid_1_i;
    grant_o     = (valid_0_i & valid_1_i) ? ~last_src_i : valid_1_i;
  end
endmodule

// File: rtl/mux_2_rr_stage.sv
// mux_2_rr_stage: round-robin selects one of two word sources into a one-entry output register
module mux_2_rr_stage
  import mux_2_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mux_2_rr_stage_if.slave         src0_i,
  mux_2_rr_stage_if.slave         src1_i,
  mux_2_rr_stage_if.master        out_o,
  output src_t                    out_src_o
);
  state_t                state_q, state_d;
  logic [WORD_SIZE-1:0]  mux_out_q, mux_out_d, sel_word;
  src_t                  out_src_q, out_src_d, last_src_q, last_src_d, grant;
  logic                  any_grant, accept, in_xfer;
  arb_rr2 u_arb (
    .valid_0_i  (src0_i.valid),
    .valid_1_i  (src1_i.valid),
    .last_src_i (last_src_q),
    .grant_o    (grant),
    .any_grant_o(any_grant)
  );
  // rst_n gates accept so no source sees ready while reset is held
  always_comb begin
    accept       = rst_n & ((state_q == EMPTY) | out_o.ready);
    in_xfer      = accept & any_grant;
    sel_word     = grant ? src1_i.data : src0_i.data;
    src0_i.ready = accept & ~grant & src0_i.valid;
    src1_i.ready = accept & grant & src1_i.valid;
    state_d      = in_xfer ? FULL : (out_o.ready ? EMPTY : state_q);
    mux_out_d    = in_xfer ? sel_word : mux_out_q;
    out_src_d    = in_xfer ? grant : out_src_q;
    last_src_d   = in_xfer ? grant : last_src_q;
    out_o.data   = mux_out_q;
    out_o.valid  = state_q == FULL;
    out_src_o    = out_src_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      mux_out_q  <= '0;
      out_src_q  <= 1'b0;
      last_src_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      mux_out_q  <= mux_out_d;
      out_src_q  <= out_src_d;
      last_src_q <= last_src_d;
    end
  end
endmodule

// File: tb/tb_mux_2_rr_stage.sv
// tb_mux_2_rr_stage: directed checks of the round-robin mux stage
module tb_mux_2_rr_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_src;
  int checks = 0;
  int errors = 0;
  mux_2_rr_stage_if s0 ();
  mux_2_rr_stage_if s1 ();
  mux_2_rr_stage_if o ();
  mux_2_rr_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src0_i   (s0),
    .src1_i   (s1),
    .out_o    (o),
    .out_src_o(out_src)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask
  task automatic chk_out(input string tag, input logic [31:0] d, input logic v, input logic s);
    chk({tag, "_data"}, o.data, d);
    chk({tag, "_valid"}, {31'd0, o.valid}, {31'd0, v});
    chk({tag, "_src"}, {31'd0, out_src}, {31'd0, s});
  endtask
  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    #1;
    chk({tag, "_rdy0"}, {31'd0, s0.ready}, {31'd0, r0});
    chk({tag, "_rdy1"}, {31'd0, s1.ready}, {31'd0, r1});
  endtask
  initial begin
    logic [31:0] n0, n1;
    s0.valid = 1'b1; s0.data = 32'h0;
    s1.valid = 1'b1; s1.data = 32'h0;
    o.ready  = 1'b1;
    chk_rdy("in_reset", 1'b0, 1'b0);
    repeat (3) tick();
    chk_out("reset", 32'h0, 1'b0, 1'b0);
    s0.valid = 1'b0; s1.valid = 1'b0;
    rst_n = 1'b1;
    // single source
    s0.valid = 1'b1; s0.data = 32'hA5A5_0001;
    chk_rdy("single", 1'b1, 1'b0);
    tick();
    s0.valid = 1'b0;
    chk_out("single", 32'hA5A5_0001, 1'b1, 1'b0);
    // contention from a fresh reset
    do_reset();
    n0 = 0; n1 = 0;
    s0.valid = 1'b1; s1.valid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      s0.data = n0;
      s1.data = 32'h1000_0000 + n1;
      chk_rdy($sformatf("cont%0d", n), n % 2 == 0, n % 2 == 1);
      tick();
      chk_out($sformatf("cont%0d", n), (n % 2 == 1) ? 32'h1000_0000 + n1 : n0, 1'b1, n % 2 == 1);
      if (n % 2 == 1) n1++; else n0++;
    end
    s0.valid = 1'b0; s1.valid = 1'b0;
    // back-pressure: load DEAD_BEEF then stall
    s0.valid = 1'b1; s0.data = 32'hDEAD_BEEF;
    tick();
    chk_out("load_beef", 32'hDEAD_BEEF, 1'b1, 1'b0);
    o.ready = 1'b0;
    s0.data = 32'h0000_00A0;
    s1.valid = 1'b1; s1.data = 32'h1111_0000;
    for (int k = 0; k < 4; k++) begin
      chk_rdy($sformatf("stall%0d", k), 1'b0, 1'b0);
      tick();
      chk_out($sformatf("stall%0d", k), 32'hDEAD_BEEF, 1'b1, 1'b0);
    end
    o.ready = 1'b1;
    chk_rdy("unstall", 1'b0, 1'b1);
    tick();
    chk_out("unstall", 32'h1111_0000, 1'b1, 1'b1);
    s1.valid = 1'b0;
    chk_rdy("drain0", 1'b1, 1'b0);
    tick();
    chk_out("drain0", 32'h0000_00A0, 1'b1, 1'b0);
    // pass-through from FULL
    s0.valid = 1'b0;
    s1.valid = 1'b1; s1.data = 32'h2222_0000;
    chk_rdy("pass", 1'b0, 1'b1);
    tick();
    chk_out("pass", 32'h2222_0000, 1'b1, 1'b1);
    // mid-cycle asynchronous reset while FULL with out_src=1
    s1.valid = 1'b0; o.ready = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_out("async_rst", 32'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    o.ready = 1'b1;
    s0.valid = 1'b1; s0.data = 32'h3333_0000;
    s1.valid = 1'b1; s1.data = 32'h4444_0000;
    chk_rdy("post_rst", 1'b1, 1'b0);
    tick();
    chk_out("post_rst", 32'h3333_0000, 1'b1, 1'b0);
    // idle gaps keep last_src
    s0.valid = 1'b0;
    s1.data = 32'h5555_0001;
    chk_rdy("idle_src1", 1'b0, 1'b1);
    tick();
    chk_out("idle_src1", 32'h5555_0001, 1'b1, 1'b1);
    s1.valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk({$sformatf("idle%0d", k), "_valid"}, {31'd0, o.valid}, 32'd0);
    end
    s0.valid = 1'b1; s0.data = 32'h6666_0000;
    s1.valid = 1'b1; s1.data = 32'h7777_0000;
    chk_rdy("after_idle", 1'b1, 1'b0);
    tick();
    chk_out("after_idle", 32'h6666_0000, 1'b1, 1'b0);
    s0.valid = 1'b0; s1.valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
